rom_ws: RTL and testbench
=========================

// Module: rom_ws
// PURPOSE
//   Clocked, parametrised boot/program ROM with programmable wait states and
//   req/ack handshake. Replaces the combinational ROM on the core data/instr bus.
//   Supports byte/half/word reads with zero- or sign-extension, plus alignment
//   and range error reporting. Sits behind the bus decoder, which drives cs_i.
// PARAMETERS
//   DEPTH        256          number of 32-bit words (power of two, >=4)
//   INIT_FILE    "image.hex"  $readmemh image loaded at elaboration
//   BASE_ADDR    32'h0        byte address of word 0 (word-aligned)
//   WAIT_STATES  1            extra cycles before ack (0..15)
//   (local) AW = $clog2(DEPTH), WS_W = 4
// PORTS
//   clk_i      in   1   clock, rising edge
//   rst_ni     in   1   asynchronous reset, active-low
//   cs_i       in   1   chip select from bus decoder
//   req_i      in   1   read request; sampled only while ready_o=1
//   addr_i     in   32  byte address
//   hb_i       in   2   size: 01 byte, 10 half, 00/11 word
//   sx_i       in   1   1 = sign-extend byte/half, 0 = zero-extend
//   ready_o    out  1   block can accept a request this cycle
//   ack_o      out  1   one-cycle response strobe; rdata_o/err_o valid
//   rdata_o    out  32  read data, held until next ack
//   err_o      out  1   response is an error (valid with ack_o only)
// BEHAVIOUR
//   - Reset (rst_ni=0, async): state IDLE, ack_o=0, err_o=0, rdata_o=0,
//     wait counter=0, ready_o=1. An in-flight request is dropped, never acked.
//   - States IDLE, WAIT, RESP. ready_o = (state != WAIT).
//   - Accept: ready_o & cs_i & req_i at rising edge. Latch addr[1:0], hb, sx,
//     error flag; fetch rom[(addr_i-BASE_ADDR)>>2] into word register.
//     WAIT_STATES=0 -> RESP; else counter<=WAIT_STATES-1, -> WAIT.
//   - WAIT: counter decrements each cycle; at 0 -> RESP. Inputs ignored.
//   - RESP: ack_o=1 for exactly this cycle. Accept allowed in RESP
//     (back-to-back); else -> IDLE. Throughput 1/cycle when WAIT_STATES=0.
//   - Latency: accept edge to ack cycle = WAIT_STATES+1 cycles.
//   - Lane select: byte lane = addr[1:0] (00 -> [7:0] .. 11 -> [31:24]);
//     half lane = addr[1] (0 -> [15:0], 1 -> [31:16]); word = full word.
//     Upper bits: sx_i=1 replicate lane MSB, else 0. sx_i ignored for word.
//   - Errors (err_o=1, rdata_o=0 on ack): half with addr[0]=1; word with
//     addr[1:0]!=0; addr_i<BASE_ADDR or word index >= DEPTH. Error responses
//     take the same latency as good ones.
//   - rdata_o/err_o update only on the ack cycle; held otherwise.
//   - cs_i=0 with req_i=1: ignored, no ack. No write path; ROM is read-only.
// STRUCTURE
//   - Shared package pygmy_pkg: HB_BYTE=2'b01, HB_HALF=2'b10, HB_WORD=2'b00,
//     rom_ws state encoding localparams.
//   - Sub-module load_align (combinational): word, addr[1:0], hb, sx ->
//     aligned 32-bit data + misalign flag; reused later by RAM/LSU.
//   - FSM, wait counter and output registers stay in rom_ws.
// TESTING (image: word0=32'h8899AABB, word1=32'h12345678, WAIT_STATES=2)
//   - Word read addr 0 -> ack_o exactly 3 cycles after accept, rdata_o=8899AABB,
//     err_o=0; ready_o=0 during the 2 wait cycles.
//   - Byte reads addr 0..3, sx=1 -> FFFFFFBB, FFFFFFAA, FFFFFF99, FFFFFF88;
//     sx=0 -> 000000BB..00000088.
//   - Half addr 2 sx=1 -> FFFF8899; half addr 6 sx=0 -> 00001234; half addr 1
//     -> ack with err_o=1, rdata_o=0.
//   - Word at byte addr DEPTH*4 -> err_o=1 after same latency; word addr 5
//     (misaligned) -> err_o=1.
//   - WAIT_STATES=0 build: req held high addr 0 then 4 on consecutive cycles ->
//     acks on consecutive cycles with 8899AABB, 12345678.
//   - Assert rst_ni low during WAIT -> outputs zero immediately, no ack after
//     release; next request completes normally.

Source files
------------

// File: rtl/pygmy_pkg.sv
// Shared bus-side definitions: access-size codes and the rom_ws state encoding.
package pygmy_pkg;

  // Access size codes carried on hb_i (2'b11 also decodes as a word access).
  localparam logic [1:0] HB_BYTE = 2'b01;
  localparam logic [1:0] HB_HALF = 2'b10;
  localparam logic [1:0] HB_WORD = 2'b00;

  // Width of the rom_ws wait-state counter (supports 0..15 wait states).
  localparam int WS_W = 4;

  typedef enum logic [1:0] {
    ROM_IDLE = 2'd0,
    ROM_WAIT = 2'd1,
    ROM_RESP = 2'd2
  } rom_state_e;

endpackage

// File: rtl/load_align.sv
// Load aligner: picks the byte/half/word lane out of a 32-bit word, extends it,
// and flags accesses that are not naturally aligned. Purely combinational so it
// can sit behind any registered word source (ROM, RAM, LSU).
module load_align
  import pygmy_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_hb,
  input  logic        i_sx,
  output logic [31:0] o_data,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  // Lane select with zero/sign extension and alignment check per access size.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_data     = i_word;
    o_misalign = 1'b0;
    case (i_hb)
      HB_BYTE: begin
        o_data = {{24{i_sx & w_byte[7]}}, w_byte};
      end
      HB_HALF: begin
        o_data     = {{16{i_sx & w_half[15]}}, w_half};
        o_misalign = i_lane[0];
      end
      default: begin
        o_misalign = (i_lane != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/rom_ws.sv
// Clocked read-only program ROM with a programmable number of wait states and a
// req/ack handshake. The image is supplied as a packed parameter (word 0 in the
// least significant 32 bits), so the array reduces to constant logic.
// Flow: accept -> (WAIT x WAIT_STATES) -> RESP (one-cycle ack) -> IDLE/accept.
module rom_ws
  import pygmy_pkg::*;
#(
  parameter int                  DEPTH       = 256,
  parameter logic [DEPTH*32-1:0] INIT_IMAGE  = '0,
  parameter logic [31:0]         BASE_ADDR   = 32'h0,
  parameter int                  WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cs_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  hb_i,
  input  logic        sx_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WS_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? WS_W'(WAIT_STATES - 1) : '0;

  rom_state_e        r_state, w_state_nx;
  logic [WS_W-1:0]   r_cnt, w_cnt_nx;

  // Request fields captured at accept, replayed when the wait count expires.
  logic [31:0]       r_word;
  logic [1:0]        r_lane;
  logic [1:0]        r_hb;
  logic              r_sx;
  logic              r_range_err;

  logic              w_accept;
  logic [29:0]       w_word_off;
  logic [AW-1:0]     w_idx;
  logic              w_range_err;
  logic [31:0]       w_rom_word;
  logic              w_from_latch;
  logic [31:0]       w_src_word;
  logic [1:0]        w_src_lane;
  logic [1:0]        w_src_hb;
  logic              w_src_sx;
  logic              w_src_range;
  logic [31:0]       w_aligned;
  logic              w_misalign;

  assign ready_o  = (r_state != ROM_WAIT);
  assign ack_o    = (r_state == ROM_RESP);
  assign w_accept = ready_o & cs_i & req_i;

  // BASE_ADDR is word-aligned, so the word offset only needs address bits [31:2];
  // a borrow or any bit above the index means the access is outside the ROM.
  assign w_word_off  = addr_i[31:2] - BASE_ADDR[31:2];
  assign w_idx       = w_word_off[AW-1:0];
  assign w_range_err = (addr_i[31:2] < BASE_ADDR[31:2]) | (|w_word_off[29:AW]);
  assign w_rom_word  = INIT_IMAGE[{w_idx, 5'd0} +: 32];

  // Leaving WAIT uses the captured request; a zero-wait accept uses live inputs.
  assign w_from_latch = (r_state == ROM_WAIT);
  assign w_src_word   = w_from_latch ? r_word      : w_rom_word;
  assign w_src_lane   = w_from_latch ? r_lane      : addr_i[1:0];
  assign w_src_hb     = w_from_latch ? r_hb        : hb_i;
  assign w_src_sx     = w_from_latch ? r_sx        : sx_i;
  assign w_src_range  = w_from_latch ? r_range_err : w_range_err;

  load_align u_align (
    .i_word     (w_src_word),
    .i_lane     (w_src_lane),
    .i_hb       (w_src_hb),
    .i_sx       (w_src_sx),
    .o_data     (w_aligned),
    .o_misalign (w_misalign)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ROM_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nx = ROM_RESP;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      default: begin
        if (!w_accept) begin
          w_state_nx = ROM_IDLE;
        end else if (WAIT_STATES == 0) begin
          w_state_nx = ROM_RESP;
        end else begin
          w_state_nx = ROM_WAIT;
          w_cnt_nx   = WS_LOAD;
        end
      end
    endcase
  end

  // State and counter registers; reset drops any in-flight request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_ni) begin
      r_state <= ROM_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Capture the request on accept for replay at the end of the wait period.
  always_ff @(posedge clk_i) begin
    // NOTE: pure datapath capture is left without reset; it is only consumed
    // after a fresh accept has written it, so a reset would buy nothing.
    if (w_accept) begin
      r_word      <= w_rom_word;
      r_lane      <= addr_i[1:0];
      r_hb        <= hb_i;
      r_sx        <= sx_i;
      r_range_err <= w_range_err;
    end
  end

  // Response registers load on entry to RESP and hold until the next response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else if (w_state_nx == ROM_RESP) begin
      err_o   <= w_src_range | w_misalign;
      rdata_o <= (w_src_range | w_misalign) ? 32'h0 : w_aligned;
    end
  end

endmodule

// File: tb/tb_rom_ws.sv
// Scoreboard bench for rom_ws: a 2-wait-state instance and a zero-wait instance.
// Drivers push expected responses (data, err, ack cycle); monitors pop on ack_o.
module tb_rom_ws;
  import pygmy_pkg::*;

  localparam int DEPTH = 256;
  localparam logic [DEPTH*32-1:0] IMG =
    {{(DEPTH-2){32'h0}}, 32'h12345678, 32'h8899AABB};

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ack_cnt2 = 0;
  int   ack_cnt0 = 0;

  exp_t q2[$];
  exp_t q0[$];
  exp_t e2, e0;

  // Instance with two wait states.
  logic        cs2 = 0, req2 = 0, sx2 = 0;
  logic [31:0] addr2 = 0;
  logic [1:0]  hb2 = HB_WORD;
  logic        ready2, ack2, err2;
  logic [31:0] rdata2;

  // Instance with zero wait states.
  logic        cs0 = 0, req0 = 0, sx0 = 0;
  logic [31:0] addr0 = 0;
  logic [1:0]  hb0 = HB_WORD;
  logic        ready0, ack0, err0;
  logic [31:0] rdata0;

  rom_ws #(.DEPTH(DEPTH), .INIT_IMAGE(IMG), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .cs_i(cs2), .req_i(req2), .addr_i(addr2),
    .hb_i(hb2), .sx_i(sx2), .ready_o(ready2), .ack_o(ack2), .rdata_o(rdata2),
    .err_o(err2)
  );

  rom_ws #(.DEPTH(DEPTH), .INIT_IMAGE(IMG), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .cs_i(cs0), .req_i(req0), .addr_i(addr0),
    .hb_i(hb0), .sx_i(sx0), .ready_o(ready0), .ack_o(ack0), .rdata_o(rdata0),
    .err_o(err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor for the 2-wait-state instance.
  always @(negedge clk) begin
    if (rst_n && ack2) begin
      ack_cnt2++;
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ws2_unexpected_ack: got ack rdata %h, expected no ack", rdata2);
      end else begin
        e2 = q2.pop_front();
        check({e2.name, "_data"}, rdata2, e2.data);
        check({e2.name, "_err"}, {31'h0, err2}, {31'h0, e2.err});
        check({e2.name, "_ackcyc"}, 32'(cyc), 32'(e2.cyc));
      end
    end
  end

  // Monitor for the zero-wait instance.
  always @(negedge clk) begin
    if (rst_n && ack0) begin
      ack_cnt0++;
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ws0_unexpected_ack: got ack rdata %h, expected no ack", rdata0);
      end else begin
        e0 = q0.pop_front();
        check({e0.name, "_data"}, rdata0, e0.data);
        check({e0.name, "_err"}, {31'h0, err0}, {31'h0, e0.err});
        check({e0.name, "_ackcyc"}, 32'(cyc), 32'(e0.cyc));
      end
    end
  end

  // One request on the 2-wait instance; ack is due two edges after the accept edge.
  task automatic issue2(input logic [31:0] a, input logic [1:0] hb, input logic sx,
                        input logic [31:0] d, input logic e, input string nm);
    exp_t x;
    @(negedge clk);
    cs2 = 1'b1; req2 = 1'b1; addr2 = a; hb2 = hb; sx2 = sx;
    @(posedge clk); #1;
    cs2 = 1'b0; req2 = 1'b0;
    x.data = d; x.err = e; x.cyc = cyc + 2; x.name = nm;
    q2.push_back(x);
  endtask

  // Zero-wait request with req held: accepted at the next edge, acked that cycle.
  task automatic step0(input logic [31:0] a, input logic [1:0] hb, input logic sx,
                       input logic [31:0] d, input logic e, input string nm);
    exp_t x;
    @(negedge clk);
    cs0 = 1'b1; req0 = 1'b1; addr0 = a; hb0 = hb; sx0 = sx;
    @(posedge clk); #1;
    x.data = d; x.err = e; x.cyc = cyc; x.name = nm;
    q0.push_back(x);
  endtask

  task automatic drain2();
    for (int i = 0; i < 20 && q2.size() != 0; i++) @(negedge clk);
    check("ws2_drain_pending", 32'(q2.size()), 32'd0);
    q2.delete();
  endtask

  task automatic drain0();
    for (int i = 0; i < 20 && q0.size() != 0; i++) @(negedge clk);
    check("ws0_drain_pending", 32'(q0.size()), 32'd0);
    q0.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ack",   {31'h0, ack2},   32'h0);
    check("rst_rdata", rdata2,          32'h0);
    check("rst_err",   {31'h0, err2},   32'h0);
    check("rst_ready", {31'h0, ready2}, 32'h1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word read with ready low through both wait cycles.
    issue2(32'h0, HB_WORD, 1'b0, 32'h8899AABB, 1'b0, "word0");
    @(negedge clk);
    check("ready_wait1", {31'h0, ready2}, 32'h0);
    @(negedge clk);
    check("ready_wait2", {31'h0, ready2}, 32'h0);
    drain2();

    // Byte lanes, sign- and zero-extended.
    issue2(32'h0, HB_BYTE, 1'b1, 32'hFFFFFFBB, 1'b0, "byte0_sx"); drain2();
    issue2(32'h1, HB_BYTE, 1'b1, 32'hFFFFFFAA, 1'b0, "byte1_sx"); drain2();
    issue2(32'h2, HB_BYTE, 1'b1, 32'hFFFFFF99, 1'b0, "byte2_sx"); drain2();
    issue2(32'h3, HB_BYTE, 1'b1, 32'hFFFFFF88, 1'b0, "byte3_sx"); drain2();
    issue2(32'h0, HB_BYTE, 1'b0, 32'h000000BB, 1'b0, "byte0_zx"); drain2();
    issue2(32'h1, HB_BYTE, 1'b0, 32'h000000AA, 1'b0, "byte1_zx"); drain2();
    issue2(32'h2, HB_BYTE, 1'b0, 32'h00000099, 1'b0, "byte2_zx"); drain2();
    issue2(32'h3, HB_BYTE, 1'b0, 32'h00000088, 1'b0, "byte3_zx"); drain2();
    issue2(32'h7, HB_BYTE, 1'b1, 32'h00000012, 1'b0, "byte7_sx_pos"); drain2();

    // Halves, errors and boundaries.
    issue2(32'h2, HB_HALF, 1'b1, 32'hFFFF8899, 1'b0, "half2_sx"); drain2();
    issue2(32'h0, HB_HALF, 1'b1, 32'hFFFFAABB, 1'b0, "half0_sx"); drain2();
    issue2(32'h6, HB_HALF, 1'b0, 32'h00001234, 1'b0, "half6_zx"); drain2();
    issue2(32'h4, HB_HALF, 1'b1, 32'h00005678, 1'b0, "half4_sx_pos"); drain2();
    issue2(32'h1, HB_HALF, 1'b1, 32'h00000000, 1'b1, "half1_misalign"); drain2();
    issue2(32'h4, 2'b11,   1'b1, 32'h12345678, 1'b0, "word4_hb11"); drain2();
    issue2(DEPTH*4, HB_WORD, 1'b0, 32'h00000000, 1'b1, "word_range"); drain2();
    issue2(32'h5, HB_WORD, 1'b0, 32'h00000000, 1'b1, "word5_misalign"); drain2();
    issue2(DEPTH*4-4, HB_WORD, 1'b0, 32'h00000000, 1'b0, "word_last"); drain2();
    issue2(32'h4, HB_WORD, 1'b0, 32'h12345678, 1'b0, "word4"); drain2();

    // Request without chip select must be ignored.
    saved = ack_cnt2;
    @(negedge clk);
    cs2 = 1'b0; req2 = 1'b1; addr2 = 32'h0; hb2 = HB_WORD;
    @(posedge clk); #1;
    req2 = 1'b0;
    repeat (6) @(negedge clk);
    check("nocs_no_ack", 32'(ack_cnt2), 32'(saved));

    // Reset during WAIT: outputs clear at once, the request is never acked.
    @(negedge clk);
    cs2 = 1'b1; req2 = 1'b1; addr2 = 32'h0; hb2 = HB_WORD;
    @(posedge clk); #1;
    cs2 = 1'b0; req2 = 1'b0;
    @(negedge clk);
    check("pre_rst_rdata_held", rdata2, 32'h12345678);
    saved = ack_cnt2;
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", rdata2,          32'h0);
    check("midrst_err",   {31'h0, err2},   32'h0);
    check("midrst_ack",   {31'h0, ack2},   32'h0);
    check("midrst_ready", {31'h0, ready2}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_dropped_no_ack", 32'(ack_cnt2), 32'(saved));
    issue2(32'h0, HB_WORD, 1'b0, 32'h8899AABB, 1'b0, "post_rst_word0"); drain2();

    // Zero-wait instance: back-to-back accepts with req held high.
    step0(32'h0, HB_WORD, 1'b0, 32'h8899AABB, 1'b0, "b2b_word0");
    step0(32'h4, HB_WORD, 1'b0, 32'h12345678, 1'b0, "b2b_word4");
    step0(32'h5, HB_WORD, 1'b0, 32'h00000000, 1'b1, "b2b_word5_err");
    step0(32'h3, HB_BYTE, 1'b1, 32'hFFFFFF88, 1'b0, "b2b_byte3_sx");
    @(negedge clk);
    cs0 = 1'b0; req0 = 1'b0;
    drain0();
    check("ws0_ack_count", 32'(ack_cnt0), 32'd4);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
